// File: rtl/serial_pkg.sv
// Shared definitions for the enable-qualified serial bit path (tx and rx).
// SERIAL_TX_PARITY_EN appends an even-parity bit to every frame.
package serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits per frame: data word plus the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef SERIAL_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_bit_tx_if.sv
// Load handshake, bit-rate tick and serial output bundle of serial_bit_tx.
interface serial_bit_tx_if #(
  parameter int unsigned WIDTH = serial_pkg::DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             tick;
  logic             d_out;
  logic             en_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid, tick,
    input  load_ready, d_out, en_out, busy, done
  );

  modport slave (
    input  data_in, load_valid, tick,
    output load_ready, d_out, en_out, busy, done
  );

endinterface

// File: rtl/tx_bit_counter.sv
// Emitted-bit counter: clear, tick-qualified increment, terminal count at LIMIT-1.
// Saturates at LIMIT so it can never wrap back into a live frame.
module tx_bit_counter #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CW'(LIMIT))) begin
      count <= count + CW'(1);
    end
  end

  assign tc_c = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: LSB-first, one bit per tick with an en_out strobe.
// Optional even parity bit after the MSB under SERIAL_TX_PARITY_EN.
module serial_bit_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  serial_bit_tx_if.slave bus
);

  localparam int unsigned FRAME = frame_len(WIDTH);

  state_t           state, state_nxt;
  logic [FRAME-1:0] shreg, shreg_nxt;
  logic [FRAME-1:0] load_word;
  logic             last_q, last_nxt;
  logic             d_q, d_nxt;
  logic             en_q, en_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             cnt_clr, cnt_inc, cnt_tc;

  // Parity is frozen at load so later data_in changes cannot disturb it.
`ifdef SERIAL_TX_PARITY_EN
  assign load_word = {^bus.data_in, bus.data_in};
`else
  assign load_word = bus.data_in;
`endif

  tx_bit_counter #(
    .LIMIT (FRAME)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .tc_c  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      last_q <= 1'b0;
      d_q    <= 1'b0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      last_q <= last_nxt;
      d_q    <= d_nxt;
      en_q   <= en_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // last_q marks that the final bit is on the wire; the next cycle enters DONE.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    last_nxt  = last_q;
    d_nxt     = d_q;
    en_nxt    = 1'b0;
    done_nxt  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.load_valid) begin
          shreg_nxt = load_word;
          cnt_clr   = 1'b1;
          last_nxt  = 1'b0;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_q) begin
          done_nxt  = 1'b1;
          last_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end else if (bus.tick) begin
          d_nxt     = shreg[0];
          en_nxt    = 1'b1;
          shreg_nxt = {1'b0, shreg[FRAME-1:1]};
          cnt_inc   = 1'b1;
          last_nxt  = cnt_tc;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign bus.load_ready = (state == ST_IDLE) && !reset;
  assign bus.d_out      = d_q;
  assign bus.en_out     = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
